// File: rtl/fibo_req_arbiter.sv
// fibo_req_arbiter: two-requester arbiter sharing one Fibonacci FSM, with watchdog abort; define FIBO_ARB_FIXED_PRIO_EN for fixed priority
module fibo_req_arbiter #(
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] n0,
  input  logic [DATA_W-1:0] n1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic              fib_start,
  output logic [DATA_W-1:0] fib_n,
  input  logic              fib_done,
  input  logic [DATA_W-1:0] fib_result,
  output logic              fib_rst
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, RESP, ABORT} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic last, owner, pick1;
  // choose requester 1 only when it alone asks or wins the tie
`ifdef FIBO_ARB_FIXED_PRIO_EN
  always_comb pick1 = req1 & ~req0;
`else
  always_comb pick1 = req1 & (~req0 | ~last);
`endif
  // datapath reset follows the arbiter reset and the abort cycle
  always_comb fib_rst = rst | (state == ABORT);
  // arbitration, launch, watchdog and response sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err <= 1'b0;
      fib_start <= 1'b0;
      result <= '0;
      fib_n <= '0;
      timer <= '0;
      last <= 1'b1;
      owner <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          gnt0 <= ~pick1;
          gnt1 <= pick1;
          owner <= pick1;
          fib_n <= pick1 ? n1 : n0;
          fib_start <= 1'b1;
          state <= LAUNCH;
        end
        LAUNCH: begin
          fib_start <= 1'b0;
          timer <= '0;
          state <= BUSY;
        end
        BUSY: begin
          timer <= timer + 1'b1;
          if (fib_done) begin
            result <= fib_result;
            ack0 <= ~owner;
            ack1 <= owner;
            state <= RESP;
          end else if (timer == T_LAST) begin
            ack0 <= ~owner;
            ack1 <= owner;
            err <= 1'b1;
            state <= ABORT;
          end
        end
        RESP, ABORT: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          err <= 1'b0;
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          last <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
